vram_arbiter: RTL and testbench

- Shares one single-port video RAM between the LC-3 CPU memory interface and the VGA pixel path.
- Prefetches 1bpp framebuffer words (16 pixels/word, MSB = leftmost) into a 2-entry FIFO.
- Serializes the FIFO head word to a pixel bit using the X/Y coordinates from the VGA timing controller.
- The CPU is granted every RAM slot the video prefetch does not need.

---
 rtl/vram_arbiter_if.sv | 40 ++++
 rtl/vram_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Bus bundle for vram_arbiter: VGA timing inputs, CPU handshake, VRAM port and pixel status.
// slave = arbiter view, master = environment (CPU, RAM, VGA timing) view.
interface vram_arbiter_if #(
    parameter int ADDR_W = 15
);
    logic [9:0]        X;
    logic [9:0]        Y;
    logic              PIX_STROBE;
    logic              BLANK_N;
    logic              CPU_REQ;
    logic              CPU_WE;
    logic [ADDR_W-1:0] CPU_ADDR;
    logic [15:0]       CPU_WDATA;
    logic              CPU_ACK;
    logic [15:0]       CPU_RDATA;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic              MEM_WE;
    logic [15:0]       MEM_WDATA;
    logic [15:0]       MEM_RDATA;
    logic              PIX_OUT;
    logic              UNDERFLOW;

    modport slave (
        input  X, Y, PIX_STROBE, BLANK_N,
        input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
        output CPU_ACK, CPU_RDATA,
        output MEM_ADDR, MEM_WE, MEM_WDATA,
        input  MEM_RDATA,
        output PIX_OUT, UNDERFLOW
    );

    modport master (
        output X, Y, PIX_STROBE, BLANK_N,
        output CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
        input  CPU_ACK, CPU_RDATA,
        input  MEM_ADDR, MEM_WE, MEM_WDATA,
        output MEM_RDATA,
        input  PIX_OUT, UNDERFLOW
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: 1bpp video prefetch into a 2-entry FIFO, CPU gets the spare slots.
// Define VRAM_UNDERFLOW_CNT_EN to add the saturating UNDERFLOW_CNT output.
//
// CPU FSM states:
//   state  | meaning
//   C_IDLE | no access; a request is granted at once if video does not need the slot
//   C_WAIT | request pending, video took the slot
//   C_RD   | read issued, waiting for the CPU tag to leave the return pipe
//   C_ACK  | access complete; CPU_ACK pulses on the next cycle
//   C_HOLD | waiting for CPU_REQ to drop
module vram_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int FB_WORDS = 19200,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int RD_LAT   = 2
) (
    input  logic          Clk,
    input  logic          Reset_N,
    vram_arbiter_if.slave bus
`ifdef VRAM_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]   UNDERFLOW_CNT
`endif
);

    typedef enum logic [2:0] {C_IDLE, C_WAIT, C_RD, C_ACK, C_HOLD} cpu_state_t;

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_VID  = 2'd1;
    localparam logic [1:0] TAG_CPU  = 2'd2;

    cpu_state_t              cst_q, cst_d;
    logic [ADDR_W:0]         vid_addr_q, vid_addr_d;
    logic [1:0][15:0]        fifo_q, fifo_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [RD_LAT:0][1:0]    tag_q, tag_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic                    mem_we_q, mem_we_d;
    logic [15:0]             mem_wdata_q, mem_wdata_d;
    logic [15:0]             rdata_q, rdata_d;
    logic                    ack_q, ack_d;
    logic                    underflow_q, underflow_d;

    logic                    fetch_en;
    logic [2:0]              vid_inflight;
    logic [2:0]              occupancy;
    logic                    vid_issue;
    logic                    cpu_pending;
    logic                    cpu_grant;
    logic [1:0]              new_tag;
    logic [1:0]              ret_tag;
    logic                    push;
    logic                    pop_req;
    logic                    pop;
    logic                    underflow_evt;
    logic [3:0]              bit_idx;

    // Line V_TOTAL-1 is the prefill line: fetching restarts there so line 0 starts with a full FIFO.
    assign fetch_en = !((bus.Y >= 10'(V_ACTIVE)) && (bus.Y != 10'(V_TOTAL - 1)));

    always_comb begin
        vid_inflight = '0;
        for (int i = 0; i <= RD_LAT; i++) begin
            if (tag_q[i] == TAG_VID) vid_inflight = vid_inflight + 3'd1;
        end
    end

    assign occupancy   = 3'(cnt_q) + vid_inflight;
    assign vid_issue   = fetch_en && (occupancy < 3'd2) && (vid_addr_q < (ADDR_W + 1)'(FB_WORDS));
    assign cpu_pending = ((cst_q == C_IDLE) && bus.CPU_REQ) || (cst_q == C_WAIT);
    assign cpu_grant   = cpu_pending && !vid_issue;
    assign ret_tag     = tag_q[RD_LAT];

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        new_tag     = TAG_NONE;
        if (vid_issue) begin
            mem_addr_d = vid_addr_q[ADDR_W-1:0];
            new_tag    = TAG_VID;
        end else if (cpu_grant) begin
            mem_addr_d  = bus.CPU_ADDR;
            mem_we_d    = bus.CPU_WE;
            mem_wdata_d = bus.CPU_WDATA;
            new_tag     = bus.CPU_WE ? TAG_NONE : TAG_CPU;
        end
    end

    // Video tags already in flight are dropped when fetching stops, so their data is never pushed.
    always_comb begin
        tag_d[0] = new_tag;
        for (int i = 1; i <= RD_LAT; i++) tag_d[i] = tag_q[i-1];
        for (int i = 0; i <= RD_LAT; i++) begin
            if (!fetch_en && (tag_d[i] == TAG_VID)) tag_d[i] = TAG_NONE;
        end
    end

    always_comb begin
        vid_addr_d = vid_addr_q;
        if (!fetch_en)      vid_addr_d = '0;
        else if (vid_issue) vid_addr_d = vid_addr_q + 1'b1;
    end

    assign push          = (ret_tag == TAG_VID) && fetch_en;
    assign pop_req       = bus.PIX_STROBE && bus.BLANK_N && (bus.X[3:0] == 4'hF);
    assign pop           = pop_req && (cnt_q != 2'd0);
    assign underflow_evt = pop_req && (cnt_q == 2'd0);
    assign underflow_d   = underflow_q | underflow_evt;

    always_comb begin
        fifo_d = fifo_q;
        cnt_d  = cnt_q;
        if (pop) begin
            fifo_d[0] = fifo_q[1];
            cnt_d     = cnt_q - 2'd1;
        end
        if (push) begin
            if (cnt_d == 2'd0) fifo_d[0] = bus.MEM_RDATA;
            else               fifo_d[1] = bus.MEM_RDATA;
            cnt_d = cnt_d + 2'd1;
        end
        if (!fetch_en) cnt_d = 2'd0;
    end

    always_comb begin
        cst_d   = cst_q;
        rdata_d = rdata_q;
        ack_d   = (cst_q == C_ACK);
        case (cst_q)
            C_IDLE, C_WAIT: begin
                if (cpu_grant)        cst_d = bus.CPU_WE ? C_ACK : C_RD;
                else if (cpu_pending) cst_d = C_WAIT;
            end
            C_RD: begin
                if (ret_tag == TAG_CPU) begin
                    rdata_d = bus.MEM_RDATA;
                    cst_d   = C_ACK;
                end
            end
            C_ACK:   cst_d = C_HOLD;
            C_HOLD:  if (!bus.CPU_REQ) cst_d = C_IDLE;
            default: cst_d = C_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            cst_q       <= C_IDLE;
            vid_addr_q  <= '0;
            fifo_q      <= '0;
            cnt_q       <= '0;
            tag_q       <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            ack_q       <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            cst_q       <= cst_d;
            vid_addr_q  <= vid_addr_d;
            fifo_q      <= fifo_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef VRAM_UNDERFLOW_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (underflow_evt && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) ucnt_q <= '0;
        else          ucnt_q <= ucnt_d;
    end

    assign UNDERFLOW_CNT = ucnt_q;
`endif

    // Leftmost pixel is the word MSB, so bit index is 15 - X[3:0].
    assign bit_idx       = ~bus.X[3:0];
    assign bus.PIX_OUT   = bus.BLANK_N && (cnt_q != 2'd0) && fifo_q[0][bit_idx];
    assign bus.MEM_ADDR  = mem_addr_q;
    assign bus.MEM_WE    = mem_we_q;
    assign bus.MEM_WDATA = mem_wdata_q;
    assign bus.CPU_RDATA = rdata_q;
    assign bus.CPU_ACK   = ack_q;
    assign bus.UNDERFLOW = underflow_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: reset, pixel serializer, CPU write/read latency,
// CPU traffic against active video, and FIFO underflow.
module tb_vram_arbiter;
    localparam int ADDR_W = 15;
    localparam int RD_LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    vram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef VRAM_UNDERFLOW_CNT_EN
    logic [15:0] ucnt;
`endif

    vram_arbiter #(
        .ADDR_W(ADDR_W), .FB_WORDS(19200), .V_ACTIVE(480), .V_TOTAL(525), .RD_LAT(RD_LAT)
    ) dut (
        .Clk(clk),
        .Reset_N(rst_n),
        .bus(bus)
`ifdef VRAM_UNDERFLOW_CNT_EN
        ,
        .UNDERFLOW_CNT(ucnt)
`endif
    );

    int n_checks = 0;
    int n_err    = 0;

    // RAM model: 1024 words (address bits 9:0), RD_LAT cycles from registered address to data
    logic [15:0] mem [0:1023];
    logic [15:0] rd_pipe [0:RD_LAT-1];
    bit          init_done = 1'b0;

    function automatic logic [15:0] img(input int a);
        logic [7:0] b;
        b = a[7:0];
        return {b ^ 8'h5A, ~b ^ 8'h0F};
    endfunction

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 1024; i++) mem[i] <= (i == 0) ? 16'hA5F0 : img(i);
            init_done <= 1'b1;
        end else if (bus.MEM_WE) begin
            mem[bus.MEM_ADDR[9:0]] <= bus.MEM_WDATA;
        end
        rd_pipe[0] <= mem[bus.MEM_ADDR[9:0]];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.MEM_RDATA = rd_pipe[RD_LAT-1];

    task automatic init_inputs();
        bus.X = '0; bus.Y = 10'd500; bus.PIX_STROBE = 1'b0; bus.BLANK_N = 1'b0;
        bus.CPU_REQ = 1'b0; bus.CPU_WE = 1'b0; bus.CPU_ADDR = '0; bus.CPU_WDATA = '0;
    endtask

    task automatic scan_words(input int first, input int n);
        logic [15:0] word;
        for (int w = first; w < first + n; w++) begin
            word = mem[w];
            for (int x = 0; x < 16; x++) begin
                @(negedge clk);
                bus.X = 10'(w * 16 + x);
                bus.PIX_STROBE = 1'b1;
                #1;
                n_checks++;
                if (bus.PIX_OUT !== word[15-x]) begin
                    n_err++;
                    $display("FAIL pix w%0d x%0d: got %b expected %b", w, x, bus.PIX_OUT, word[15-x]);
                end
                @(negedge clk);
                bus.PIX_STROBE = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        logic [50:0] outs;
        bit          ack_seen;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        outs = {bus.MEM_ADDR, bus.MEM_WE, bus.MEM_WDATA, bus.CPU_ACK, bus.CPU_RDATA, bus.PIX_OUT, bus.UNDERFLOW};
        n_checks++;
        if (outs !== '0) begin n_err++; $display("FAIL por_outs: got %h expected 0", outs); end
        rst_n = 1'b1;
        // start a CPU write, then reset in the middle of it
        bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b1; bus.CPU_ADDR = 15'h0300; bus.CPU_WDATA = 16'hBEEF;
        @(posedge clk); #1;
        n_checks++;
        if (bus.MEM_WE !== 1'b1) begin n_err++; $display("FAIL rst_pre_we: got %b expected 1", bus.MEM_WE); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.MEM_WE !== 1'b0) begin n_err++; $display("FAIL rst_async_we: got %b expected 0", bus.MEM_WE); end
        bus.CPU_REQ = 1'b0; bus.CPU_WE = 1'b0; bus.Y = 10'd524;
        repeat (3) begin
            @(negedge clk);
            outs = {bus.MEM_ADDR, bus.MEM_WE, bus.MEM_WDATA, bus.CPU_ACK, bus.CPU_RDATA, bus.PIX_OUT, bus.UNDERFLOW};
            n_checks++;
            if (outs !== '0) begin n_err++; $display("FAIL rst_hold_outs: got %h expected 0", outs); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.MEM_ADDR !== 15'd1) begin n_err++; $display("FAIL prefill_w1: got %h expected 1", bus.MEM_ADDR); end
        ack_seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.CPU_ACK === 1'b1) ack_seen = 1'b1;
        end
        n_checks++;
        if (bus.MEM_ADDR !== 15'd1) begin n_err++; $display("FAIL prefill_stop: got %h expected 1", bus.MEM_ADDR); end
        n_checks++;
        if (ack_seen !== 1'b0) begin n_err++; $display("FAIL lost_ack: got %b expected 0", ack_seen); end
    endtask

    task automatic test_pixel();
        logic [15:0] exp_w0;
        exp_w0 = 16'b1010_0101_1111_0000;
        @(negedge clk);
        bus.Y = 10'd0; bus.BLANK_N = 1'b1;
        for (int x = 0; x < 16; x++) begin
            @(negedge clk);
            bus.X = 10'(x);
            bus.PIX_STROBE = 1'b1;
            #1;
            n_checks++;
            if (bus.PIX_OUT !== exp_w0[15-x]) begin
                n_err++;
                $display("FAIL pix_w0 x%0d: got %b expected %b", x, bus.PIX_OUT, exp_w0[15-x]);
            end
            @(negedge clk);
            bus.PIX_STROBE = 1'b0;
        end
        scan_words(1, 3);
        n_checks++;
        if (bus.UNDERFLOW !== 1'b0) begin n_err++; $display("FAIL pix_uf: got %b expected 0", bus.UNDERFLOW); end
    endtask

    task automatic test_cpu_write();
        @(negedge clk);
        bus.Y = 10'd500; bus.BLANK_N = 1'b0; bus.X = '0;
        repeat (2) @(negedge clk);
        bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b1; bus.CPU_ADDR = 15'h0100; bus.CPU_WDATA = 16'h1234;
        @(negedge clk);
        n_checks++;
        if ({bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WDATA, bus.CPU_ACK} !== {1'b1, 15'h0100, 16'h1234, 1'b0}) begin
            n_err++;
            $display("FAIL wr_issue: got we=%b a=%h d=%h ack=%b expected we=1 a=0100 d=1234 ack=0",
                     bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WDATA, bus.CPU_ACK);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.CPU_ACK, bus.MEM_WE} !== 2'b10) begin
            n_err++; $display("FAIL wr_ack: got ack=%b we=%b expected ack=1 we=0", bus.CPU_ACK, bus.MEM_WE);
        end
        bus.CPU_REQ = 1'b0; bus.CPU_WE = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.CPU_ACK !== 1'b0) begin n_err++; $display("FAIL wr_ack_pulse: got %b expected 0", bus.CPU_ACK); end
        n_checks++;
        if (mem[10'h100] !== 16'h1234) begin n_err++; $display("FAIL wr_ram: got %h expected 1234", mem[10'h100]); end
    endtask

    task automatic test_cpu_read();
        @(negedge clk);
        bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b0; bus.CPU_ADDR = 15'h0100; bus.CPU_WDATA = 16'h0000;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_checks++;
                if ({bus.MEM_WE, bus.MEM_ADDR} !== {1'b0, 15'h0100}) begin
                    n_err++; $display("FAIL rd_issue: got we=%b a=%h expected we=0 a=0100", bus.MEM_WE, bus.MEM_ADDR);
                end
                bus.CPU_ADDR = 15'h0555;
            end
            if (k < 5) begin
                n_checks++;
                if (bus.CPU_ACK !== 1'b0) begin n_err++; $display("FAIL rd_early_ack k%0d: got 1 expected 0", k); end
            end else begin
                n_checks++;
                if ({bus.CPU_ACK, bus.CPU_RDATA} !== {1'b1, 16'h1234}) begin
                    n_err++; $display("FAIL rd_ack: got ack=%b d=%h expected ack=1 d=1234", bus.CPU_ACK, bus.CPU_RDATA);
                end
            end
        end
        bus.CPU_REQ = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.CPU_ACK !== 1'b0) begin n_err++; $display("FAIL rd_ack_pulse: got %b expected 0", bus.CPU_ACK); end
    endtask

    task automatic cpu_traffic();
        logic [15:0] d;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            d = 16'hC000 | 16'(i * 16'h0111);
            @(negedge clk);
            bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b1; bus.CPU_ADDR = 15'(16'h0200 + i); bus.CPU_WDATA = d;
            lat = 0;
            do begin @(negedge clk); lat++; end while (bus.CPU_ACK !== 1'b1 && lat < 12);
            n_checks++;
            if (bus.CPU_ACK !== 1'b1 || lat > 4) begin
                n_err++; $display("FAIL b2b_wr_lat i%0d: got %0d cycles expected <= 4", i, lat);
            end
            bus.CPU_REQ = 1'b0;
            @(negedge clk);
            bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b0; bus.CPU_WDATA = 16'h0000;
            lat = 0;
            do begin @(negedge clk); lat++; end while (bus.CPU_ACK !== 1'b1 && lat < 12);
            n_checks++;
            if (bus.CPU_ACK !== 1'b1 || lat > 7 || bus.CPU_RDATA !== d) begin
                n_err++; $display("FAIL b2b_rd i%0d: got lat=%0d d=%h expected lat<=7 d=%h", i, lat, bus.CPU_RDATA, d);
            end
            bus.CPU_REQ = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.Y = 10'd500; bus.BLANK_N = 1'b0; bus.X = '0;
        repeat (2) @(negedge clk);
        bus.Y = 10'd524;
        repeat (6) @(negedge clk);
        bus.Y = 10'd0; bus.BLANK_N = 1'b1;
        fork
            scan_words(0, 6);
            cpu_traffic();
        join
        n_checks++;
        if (bus.UNDERFLOW !== 1'b0) begin n_err++; $display("FAIL b2b_uf: got %b expected 0", bus.UNDERFLOW); end
    endtask

    task automatic test_underflow();
        @(negedge clk);
        bus.Y = 10'd500; bus.BLANK_N = 1'b0; bus.X = '0;
        repeat (2) @(negedge clk);
        bus.BLANK_N = 1'b1; bus.X = 10'd5;
        #1;
        n_checks++;
        if (bus.PIX_OUT !== 1'b0) begin n_err++; $display("FAIL empty_pix: got %b expected 0", bus.PIX_OUT); end
        n_checks++;
        if (bus.UNDERFLOW !== 1'b0) begin n_err++; $display("FAIL uf_pre: got %b expected 0", bus.UNDERFLOW); end
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            bus.X = 10'd15; bus.PIX_STROBE = 1'b1;
            #1;
            n_checks++;
            if (bus.PIX_OUT !== 1'b0) begin n_err++; $display("FAIL empty_pix15 j%0d: got %b expected 0", j, bus.PIX_OUT); end
            @(negedge clk);
            bus.PIX_STROBE = 1'b0;
        end
        n_checks++;
        if (bus.UNDERFLOW !== 1'b1) begin n_err++; $display("FAIL uf_set: got %b expected 1", bus.UNDERFLOW); end
        bus.X = 10'd3;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.UNDERFLOW !== 1'b1) begin n_err++; $display("FAIL uf_sticky: got %b expected 1", bus.UNDERFLOW); end
`ifdef VRAM_UNDERFLOW_CNT_EN
        n_checks++;
        if (ucnt !== 16'd2) begin n_err++; $display("FAIL uf_cnt: got %0d expected 2", ucnt); end
`endif
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.UNDERFLOW !== 1'b0) begin n_err++; $display("FAIL uf_rst: got %b expected 0", bus.UNDERFLOW); end
`ifdef VRAM_UNDERFLOW_CNT_EN
        n_checks++;
        if (ucnt !== 16'd0) begin n_err++; $display("FAIL uf_cnt_rst: got %0d expected 0", ucnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_pixel();
        test_cpu_write();
        test_cpu_read();
        test_back_to_back();
        test_underflow();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
